// File: rtl/golden_nonce_arbiter_pkg.sv
// rtl/golden_nonce_arbiter_pkg.sv - shared widths, state encoding and helpers for the nonce arbiter
package nonce_arb_pkg;

    localparam int NONCE_W = 32;
    localparam int DROP_W  = 16;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Index width that stays legal (>=1 bit) even for a single core.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/golden_nonce_arbiter_if.sv
// rtl/golden_nonce_arbiter_if.sv - core hit inputs and comm-side nonce output bundle
interface golden_nonce_arbiter_if
    import nonce_arb_pkg::*;
#(
    parameter int NUM_CORES = 2
);

    logic [NUM_CORES-1:0]         core_new_nonce;
    logic [NONCE_W*NUM_CORES-1:0] core_golden_nonce;
    logic                         tx_ready;
    logic                         tx_new_nonce;
    logic [NONCE_W-1:0]           tx_golden_nonce;

    modport master (
        input  core_new_nonce,
        input  core_golden_nonce,
        input  tx_ready,
        output tx_new_nonce,
        output tx_golden_nonce
    );

    modport slave (
        output core_new_nonce,
        output core_golden_nonce,
        output tx_ready,
        input  tx_new_nonce,
        input  tx_golden_nonce
    );

endinterface

// File: rtl/golden_nonce_arbiter_rr_pick.sv
// rtl/golden_nonce_arbiter_rr_pick.sv - combinational round-robin picker over pending cores
module rr_pick #(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_valid
);

    // Walk ptr, ptr+1, ... (wrapping) and keep the first requester seen.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!gnt_valid && req[(int'(ptr) + k) % NUM_CORES]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'((int'(ptr) + k) % NUM_CORES);
            end
        end
    end

endmodule

// File: rtl/golden_nonce_arbiter.sv
// rtl/golden_nonce_arbiter.sv - per-core nonce slots, round-robin grant and holdoff FSM (optional NONCE_DROP_COUNT_EN drop counter)
module golden_nonce_arbiter
    import nonce_arb_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int HOLDOFF   = 5
) (
    input  logic                  hash_clk,
    input  logic                  reset,
    golden_nonce_arbiter_if.master bus
`ifdef NONCE_DROP_COUNT_EN
    ,
    output logic [DROP_W-1:0]     drop_count
`endif
);

    localparam int IDX_W  = idx_width(NUM_CORES);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    arb_state_t            state, state_next;
    logic [HOLD_W-1:0]     hold_cnt, hold_next;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_valid;
    logic                  grant;
    logic [NUM_CORES-1:0]  pending;
    logic [NUM_CORES-1:0]  gnt_onehot;
    logic [NUM_CORES-1:0]  take;
    logic [NONCE_W-1:0]    slot [NUM_CORES];

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req       (pending),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Next state: grant only from IDLE with a consumer ready, then count down the holdoff.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        grant      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (gnt_valid && bus.tx_ready) begin
                    grant      = 1'b1;
                    state_next = ARB_HOLD;
                    hold_next  = HOLD_W'(HOLDOFF);
                end
            end
            ARB_HOLD: begin
                hold_next = hold_cnt - HOLD_W'(1);
                if (hold_cnt == HOLD_W'(1)) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // A slot accepts a new hit when empty or when it is being granted on this same edge.
    always_comb begin
        gnt_onehot = '0;
        take       = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            gnt_onehot[i] = grant && (gnt_idx == IDX_W'(i));
            take[i]       = bus.core_new_nonce[i] && (!pending[i] || gnt_onehot[i]);
        end
    end

    // FSM register, output strobe/data and round-robin pointer.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state               <= ARB_IDLE;
            hold_cnt            <= '0;
            rr_ptr              <= '0;
            bus.tx_new_nonce    <= 1'b0;
            bus.tx_golden_nonce <= '0;
        end else begin
            state            <= state_next;
            hold_cnt         <= hold_next;
            bus.tx_new_nonce <= grant;
            if (grant) begin
                bus.tx_golden_nonce <= slot[gnt_idx];
                rr_ptr              <= IDX_W'((int'(gnt_idx) + 1) % NUM_CORES);
            end
        end
    end

    // Per-core pending slots: capture wins over the clear caused by a same-edge grant.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (take[i]) begin
                    slot[i]    <= bus.core_golden_nonce[NONCE_W*i +: NONCE_W];
                    pending[i] <= 1'b1;
                end else if (gnt_onehot[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

`ifdef NONCE_DROP_COUNT_EN
    logic [4:0]        drop_n;
    logic [DROP_W:0]   drop_sum;

    // Number of hits discarded this edge (strobe into a full slot that is not being granted).
    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (bus.core_new_nonce[i] && pending[i] && !gnt_onehot[i]) begin
                drop_n = drop_n + 5'd1;
            end
        end
        drop_sum = {1'b0, drop_count} + (DROP_W + 1)'(drop_n);
    end

    // Saturating discard counter.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_sum[DROP_W]) begin
            drop_count <= '1;
        end else begin
            drop_count <= drop_sum[DROP_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// tb/tb_golden_nonce_arbiter.sv - directed self-checking bench for golden_nonce_arbiter (4 cores, HOLDOFF 5)
module tb_golden_nonce_arbiter;

    localparam int NC = 4;
    localparam int HO = 5;

    logic hash_clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    logic [31:0] mon_val [$];
    int          mon_cyc [$];
    logic        prev_strobe;

    golden_nonce_arbiter_if #(.NUM_CORES(NC)) bus ();

`ifdef NONCE_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    golden_nonce_arbiter #(
        .NUM_CORES (NC),
        .HOLDOFF   (HO)
    ) dut (
        .hash_clk (hash_clk),
        .reset    (reset),
        .bus      (bus)
`ifdef NONCE_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    always @(posedge hash_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Record every output strobe and flag back-to-back strobes.
    always @(negedge hash_clk) begin
        if (!reset && bus.tx_new_nonce) begin
            mon_val.push_back(bus.tx_golden_nonce);
            mon_cyc.push_back(cyc);
            check_eq("no_back_to_back", {31'd0, prev_strobe}, 32'd0);
        end
        prev_strobe = bus.tx_new_nonce;
    end

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        mon_val.delete();
        mon_cyc.delete();
    endtask

    task automatic set_nonce(input int core, input logic [31:0] v);
        bus.core_new_nonce[core]             = 1'b1;
        bus.core_golden_nonce[32*core +: 32] = v;
    endtask

    initial begin
        int n0;
        checks                = 0;
        errors                = 0;
        cyc                   = 0;
        prev_strobe           = 1'b0;
        reset                 = 1'b1;
        bus.core_new_nonce    = '0;
        bus.core_golden_nonce = '0;
        bus.tx_ready          = 1'b1;

        // Reset and idle
        do_reset();
        check_eq("reset_strobe", {31'd0, bus.tx_new_nonce}, 32'd0);
        check_eq("reset_nonce", bus.tx_golden_nonce, 32'd0);
        ticks(100);
        check_eq("idle_strobe_count", mon_val.size(), 32'd0);
        check_eq("idle_nonce", bus.tx_golden_nonce, 32'd0);

        // Single hit: two edges of latency, one-cycle strobe
        set_nonce(0, 32'hDEADBEEF);
        tick();
        bus.core_new_nonce = '0;
        check_eq("single_no_early", {31'd0, bus.tx_new_nonce}, 32'd0);
        tick();
        check_eq("single_strobe", {31'd0, bus.tx_new_nonce}, 32'd1);
        check_eq("single_nonce", bus.tx_golden_nonce, 32'hDEADBEEF);
        tick();
        check_eq("single_strobe_low", {31'd0, bus.tx_new_nonce}, 32'd0);
        check_eq("single_nonce_held", bus.tx_golden_nonce, 32'hDEADBEEF);
        ticks(10);

        // Simultaneous hits from all cores, rr_ptr=0
        do_reset();
        set_nonce(0, 32'h11);
        set_nonce(1, 32'h22);
        set_nonce(2, 32'h33);
        set_nonce(3, 32'h44);
        tick();
        bus.core_new_nonce = '0;
        ticks(40);
        check_eq("simul_count", mon_val.size(), 32'd4);
        if (mon_val.size() == 4) begin
            check_eq("simul_0", mon_val[0], 32'h11);
            check_eq("simul_1", mon_val[1], 32'h22);
            check_eq("simul_2", mon_val[2], 32'h33);
            check_eq("simul_3", mon_val[3], 32'h44);
            for (int i = 1; i < 4; i++) begin
                check_eq("simul_spacing", mon_cyc[i] - mon_cyc[i-1], 32'd6);
            end
        end

        // Fairness: cores 0 and 1 strobe for 60 edges
        do_reset();
        for (int k = 0; k < 60; k++) begin
            set_nonce(0, 32'hC000_0000 | k);
            set_nonce(1, 32'hC100_0000 | k);
            tick();
        end
        bus.core_new_nonce = '0;
        ticks(30);
        check_eq("fair_count", mon_val.size(), 32'd12);
        for (int i = 0; i < mon_val.size(); i++) begin
            check_eq("fair_alternate", {24'd0, mon_val[i][31:24]}, (i % 2 == 0) ? 32'hC0 : 32'hC1);
        end

        // Overflow: second hit into a full slot is discarded
        do_reset();
        bus.tx_ready = 1'b0;
        set_nonce(1, 32'hA);
        tick();
        set_nonce(1, 32'hB);
        tick();
        bus.core_new_nonce = '0;
        ticks(10);
        check_eq("ovf_blocked", mon_val.size(), 32'd0);
        bus.tx_ready = 1'b1;
        ticks(20);
        check_eq("ovf_count", mon_val.size(), 32'd1);
        check_eq("ovf_nonce", bus.tx_golden_nonce, 32'hA);
`ifdef NONCE_DROP_COUNT_EN
        check_eq("ovf_drop_count", {16'd0, drop_count}, 32'd1);
`endif

        // tx_ready dropped during HOLD does not stretch the holdoff
        do_reset();
        set_nonce(0, 32'h100);
        set_nonce(1, 32'h200);
        tick();
        bus.core_new_nonce = '0;
        tick();
        bus.tx_ready = 1'b0;
        ticks(2);
        bus.tx_ready = 1'b1;
        ticks(20);
        check_eq("hold_ready_count", mon_val.size(), 32'd2);
        if (mon_val.size() == 2) begin
            check_eq("hold_ready_spacing", mon_cyc[1] - mon_cyc[0], 32'd6);
        end

        // Reset two cycles into HOLD with core0 pending
        do_reset();
        set_nonce(0, 32'h55);
        tick();
        bus.core_new_nonce = '0;
        tick();
        set_nonce(0, 32'h66);
        tick();
        bus.core_new_nonce = '0;
        tick();
        n0 = mon_val.size();
        check_eq("midhold_first", n0, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midhold_strobe", {31'd0, bus.tx_new_nonce}, 32'd0);
        check_eq("midhold_nonce", bus.tx_golden_nonce, 32'd0);
        ticks(20);
        check_eq("midhold_no_strobe", mon_val.size(), n0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
